game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 25 ++
 rtl/game_ctrl_if.sv | 23 ++
 rtl/btn_edge.sv | 24 ++
 rtl/game_ctrl.sv | 93 +++++++++
 tb/tb_game_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state encodings and tick period helper
package game_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    PAUSE = 2'b01,
    INIT  = 2'b10,
    OVER  = 2'b11
  } game_state_e;

  localparam logic [3:0] LEVEL_MAX = 4'd15;

  // Subtract first only when it cannot wrap, then clamp to the floor.
  function automatic logic [31:0] tick_period(input logic [31:0] base,
                                              input logic [31:0] step,
                                              input logic [31:0] min_p,
                                              input logic [3:0]  lvl);
    logic [31:0] dec;
    dec = {28'd0, lvl} * step;
    if (dec >= base || (base - dec) < min_p)
      return min_p;
    return base - dec;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - game controller button, snake and status signals
interface game_ctrl_if;
  import game_pkg::*;

  logic        btn_start;
  logic        btn_pause;
  logic        hit;
  logic        food_eaten;
  game_state_e game_state;
  logic        get_food;
  logic        move_tick;
  logic [3:0]  level;

  modport master (
    input  btn_start, btn_pause, hit, food_eaten,
    output game_state, get_food, move_tick, level
  );

  modport slave (
    output btn_start, btn_pause, hit, food_eaten,
    input  game_state, get_food, move_tick, level
  );
endinterface

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop button synchronizer with rising-edge pulse
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  logic sync1, sync2, prev;

  // Flops come out of reset as "held" so a button already down is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;
endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - snake game state machine, move tick and level control
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned BASE_PERIOD     = 25_000_000,
  parameter int unsigned STEP_DEC        = 1_000_000,
  parameter int unsigned MIN_PERIOD      = 5_000_000,
  parameter int unsigned FOODS_PER_LEVEL = 5
) (
  input logic         clk,
  input logic         rst_n,
  game_ctrl_if.master bus
);
  localparam int FW = $clog2(FOODS_PER_LEVEL + 1);

  game_state_e   state_q, state_d;
  logic          start_ev, pause_ev;
  logic [31:0]   period, tick_cnt;
  logic          tick_due, move_tick_q, get_food_q;
  logic [FW-1:0] food_cnt;
  logic [3:0]    level_q;

  btn_edge u_start (.clk(clk), .rst_n(rst_n), .btn(bus.btn_start), .pulse(start_ev));
  btn_edge u_pause (.clk(clk), .rst_n(rst_n), .btn(bus.btn_pause), .pulse(pause_ev));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (start_ev) state_d = PLAY;
      PLAY:    if (bus.hit) state_d = OVER;
               else if (pause_ev) state_d = PAUSE;
      PAUSE:   if (pause_ev || start_ev) state_d = PLAY;
      OVER:    if (start_ev) state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  assign period   = tick_period(BASE_PERIOD, STEP_DEC, MIN_PERIOD, level_q);
  assign tick_due = (tick_cnt >= period - 32'd1);

  // A hit in the due cycle still clears the count but never emits the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt    <= 32'd0;
      move_tick_q <= 1'b0;
    end else begin
      move_tick_q <= 1'b0;
      case (state_q)
        PLAY: begin
          if (tick_due) begin
            tick_cnt    <= 32'd0;
            move_tick_q <= ~bus.hit;
          end else begin
            tick_cnt <= tick_cnt + 32'd1;
          end
        end
        PAUSE:   tick_cnt <= tick_cnt;
        default: tick_cnt <= 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      get_food_q <= 1'b0;
      food_cnt   <= '0;
      level_q    <= 4'd0;
    end else begin
      get_food_q <= bus.food_eaten && (state_q == PLAY) && !bus.hit;
      if (state_q == INIT) begin
        food_cnt <= '0;
        level_q  <= 4'd0;
      end else if (get_food_q) begin
        if (food_cnt == FW'(FOODS_PER_LEVEL - 1)) begin
          food_cnt <= '0;
          if (level_q != LEVEL_MAX) level_q <= level_q + 4'd1;
        end else begin
          food_cnt <= food_cnt + FW'(1);
        end
      end
    end
  end

  assign bus.game_state = state_q;
  assign bus.get_food   = get_food_q;
  assign bus.move_tick  = move_tick_q;
  assign bus.level      = level_q;
endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl against a behavioural model
module tb_game_ctrl;
  import game_pkg::*;

  localparam int BP  = 10;
  localparam int SD  = 2;
  localparam int MP  = 4;
  localparam int FPL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  game_ctrl_if bus();

  game_ctrl #(
    .BASE_PERIOD(BP), .STEP_DEC(SD), .MIN_PERIOD(MP), .FOODS_PER_LEVEL(FPL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int val; } ev_t;
  ev_t q_state[$];
  ev_t q_tick[$];
  ev_t q_food[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: button history, play-time since last move, foods and level.
  game_state_e m_st = INIT;
  int  m_level = 0, m_food = 0, m_since = 0;
  bit  m_pend = 0;
  bit  hs[3] = '{1, 1, 1};
  bit  hp[3] = '{1, 1, 1};

  always @(posedge clk) begin
    bit ev_s, ev_p, tick;
    int per;
    game_state_e nst;
    cyc++;
    if (!rst_n) begin
      m_st = INIT; m_level = 0; m_food = 0; m_since = 0; m_pend = 0;
      hs = '{1, 1, 1}; hp = '{1, 1, 1};
      q_state.delete(); q_tick.delete(); q_food.delete();
    end else begin
      ev_s = hs[1] && !hs[2];
      ev_p = hp[1] && !hp[2];
      hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = bus.btn_start;
      hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = bus.btn_pause;

      per = BP - m_level * SD;
      if (per < MP) per = MP;
      tick = (m_st == PLAY) && !bus.hit && (m_since + 1 >= per);
      if (m_st == PLAY)       m_since = tick ? 0 : m_since + 1;
      else if (m_st != PAUSE) m_since = 0;

      if (m_st == INIT) begin
        m_level = 0; m_food = 0;
      end else if (m_pend) begin
        m_food++;
        if (m_food == FPL) begin
          m_food = 0;
          if (m_level < 15) m_level++;
        end
      end
      m_pend = (m_st == PLAY) && bus.food_eaten && !bus.hit;

      if (tick)   q_tick.push_back('{cyc, m_level});
      if (m_pend) q_food.push_back('{cyc, 1});

      nst = m_st;
      case (m_st)
        INIT:  if (ev_s) nst = PLAY;
        PLAY:  if (bus.hit) nst = OVER; else if (ev_p) nst = PAUSE;
        PAUSE: if (ev_p || ev_s) nst = PLAY;
        OVER:  if (ev_s) nst = INIT;
        default: nst = INIT;
      endcase
      if (nst != m_st) q_state.push_back('{cyc, int'(nst)});
      m_st = nst;
    end
  end

  game_state_e last_st = INIT;

  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      last_st = bus.game_state;
    end else begin
      if (bus.game_state != last_st) begin
        if (q_state.size() == 0) check("state_unexpected", int'(bus.game_state), int'(last_st));
        else begin
          e = q_state.pop_front();
          check("state_cycle", cyc, e.cyc);
          check("state_value", int'(bus.game_state), e.val);
        end
        last_st = bus.game_state;
      end else if (q_state.size() != 0 && q_state[0].cyc <= cyc) begin
        e = q_state.pop_front();
        check("state_missing", int'(bus.game_state), e.val);
      end

      if (bus.move_tick) begin
        if (q_tick.size() == 0) check("tick_unexpected", int'(bus.move_tick), 0);
        else begin
          e = q_tick.pop_front();
          check("tick_cycle", cyc, e.cyc);
          check("tick_level", int'(bus.level), e.val);
        end
      end else if (q_tick.size() != 0 && q_tick[0].cyc <= cyc) begin
        e = q_tick.pop_front();
        check("tick_missing", int'(bus.move_tick), 1);
      end

      if (bus.get_food) begin
        if (q_food.size() == 0) check("food_unexpected", int'(bus.get_food), 0);
        else begin
          e = q_food.pop_front();
          check("food_cycle", cyc, e.cyc);
        end
      end else if (q_food.size() != 0 && q_food[0].cyc <= cyc) begin
        e = q_food.pop_front();
        check("food_missing", int'(bus.get_food), 1);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic press(input bit is_start);
    if (is_start) bus.btn_start = 1'b1; else bus.btn_pause = 1'b1;
    wait_cyc(4);
    if (is_start) bus.btn_start = 1'b0; else bus.btn_pause = 1'b0;
    wait_cyc(3);
  endtask

  task automatic food_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.food_eaten = 1'b1;
      wait_cyc(1);
      bus.food_eaten = 1'b0;
      wait_cyc(2);
    end
    wait_cyc(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, int'(bus.game_state), int'(INIT));
    check({tag, "_get_food"}, int'(bus.get_food), 0);
    check({tag, "_move_tick"}, int'(bus.move_tick), 0);
    check({tag, "_level"}, int'(bus.level), 0);
  endtask

  initial begin
    bus.btn_start = 1'b0; bus.btn_pause = 1'b0;
    bus.hit = 1'b0; bus.food_eaten = 1'b0;
    wait_cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(5);

    press(1'b1);
    check("start_to_play", int'(bus.game_state), int'(PLAY));
    wait_cyc(40);

    food_pulses(4);
    check("level_after_4", int'(bus.level), 2);
    wait_cyc(30);
    food_pulses(8);
    check("level_after_12", int'(bus.level), 6);
    wait_cyc(20);

    wait_cyc(2);
    press(1'b0);
    check("paused", int'(bus.game_state), int'(PAUSE));
    wait_cyc(50);
    press(1'b0);
    wait_cyc(30);

    bus.hit = 1'b1; bus.food_eaten = 1'b1;
    wait_cyc(1);
    bus.hit = 1'b0; bus.food_eaten = 1'b0;
    wait_cyc(3);
    check("hit_to_over", int'(bus.game_state), int'(OVER));

    press(1'b1);
    check("over_to_init", int'(bus.game_state), int'(INIT));
    check("init_level", int'(bus.level), 0);
    press(1'b1);
    wait_cyc(25);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(29, 0) == 0) bus.btn_start = ~bus.btn_start;
      if ($urandom_range(19, 0) == 0) bus.btn_pause = ~bus.btn_pause;
      bus.hit        = ($urandom_range(199, 0) == 0);
      bus.food_eaten = ($urandom_range(5, 0) == 0);
      wait_cyc(1);
    end
    bus.btn_start = 1'b0; bus.btn_pause = 1'b0;
    bus.hit = 1'b0; bus.food_eaten = 1'b0;
    wait_cyc(10);

    rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(5);
    press(1'b1);
    wait_cyc(15);
    bus.btn_start = 1'b1;
    wait_cyc(1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midgame_reset");
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);
    check("held_start_ignored", int'(bus.game_state), int'(INIT));
    bus.btn_start = 1'b0;
    wait_cyc(5);
    press(1'b1);
    check("restart_play", int'(bus.game_state), int'(PLAY));
    wait_cyc(30);

    check("state_queue_empty", q_state.size(), 0);
    check("tick_queue_empty", q_tick.size(), 0);
    check("food_queue_empty", q_food.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
